// File: rtl/cu_mc_pkg.sv
// cu_mc_pkg: shared types and constants for the multi-cycle control unit.
//   state_t     - control FSM states
//   op_class_t  - instruction classes reported by the decoder
//   mem_size_t  - RAM access size codes (fetch always uses SZ_LONG)
//   cu_timeout_w() - width of the memory wait counter for a given timeout
package cu_mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM_WAIT  = 3'd3,
        ST_IO_WAIT   = 3'd4,
        ST_INCREMENT = 3'd5,
        ST_HALTED    = 3'd6,
        ST_FAULT     = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ALU  = 3'd1,
        OP_LOAD = 3'd2,
        OP_JMP  = 3'd3,
        OP_HALT = 3'd4,
        OP_PUTC = 3'd5
    } op_class_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_WORD = 2'd1,
        SZ_LONG = 2'd2,
        SZ_QUAD = 2'd3
    } mem_size_t;

    localparam int CU_MEM_TIMEOUT_DEF = 255;
    localparam int CU_TIMEOUT_W       = $clog2(CU_MEM_TIMEOUT_DEF + 1);

    // Counter width able to hold values 0..timeout.
    function automatic int cu_timeout_w(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/cu_mc_if.sv
// cu_mc_if: memory read port and UART putc handshake of the control unit.
//   mem_req/mem_addr/mem_size  - read request, held until mem_ready
//   mem_ready/mem_rdata        - read completion from the RAM arbiter
//   putc/putc_ready            - character strobe to the UART and its accept
// Modports: master = control unit, slave = RAM arbiter / UART side.
interface cu_mc_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_size;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              putc;
    logic              putc_ready;

    modport master (
        output mem_req, mem_addr, mem_size, putc,
        input  mem_ready, mem_rdata, putc_ready
    );

    modport slave (
        input  mem_req, mem_addr, mem_size, putc,
        output mem_ready, mem_rdata, putc_ready
    );
endinterface

// File: rtl/cu_mc_wait_timer.sv
// cu_wait_timer: counts memory request cycles that ended without ready.
//   clk, rst    - clock, synchronous active-high reset
//   clr_i       - clear counter (state entry); wins over cnt_en_i
//   cnt_en_i    - a request cycle passed without ready
//   expired_o   - the current request cycle is the LIMIT-th one; if ready
//                 does not arrive in it, the wait has timed out
module cu_wait_timer #(
    parameter int LIMIT = 255,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic cnt_en_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_o = (cnt_q == CNT_W'(LIMIT - 1));

    // Saturate at the expiry value so a stalled owner can never wrap it.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cu_mc.sv
// cu_mc: multi-cycle control unit with handshaked memory and UART access.
// Sequence per instruction: FETCH -> DECODE -> EXECUTE -> [MEM_WAIT|IO_WAIT]
// -> INCREMENT -> FETCH, with HALTED (resume continues) and FAULT (memory
// timeout, resume retries the fetch at the same ip).
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   en_i             - global enable, 0 freezes the unit and drops strobes
//   resume_i         - leave HALTED / FAULT
//   bus              - memory read port + putc handshake (master side)
//   ir_o             - instruction register to the decoder
//   dec_*_i          - decoded op class, jump offset, load address/size
//   alu_en_o         - ALU operates this cycle
//   rf_we_o/rf_wsel_o- reg file write strobe / source (0 ALU, 1 load data)
//   ld_data_o        - captured load data
//   halted_o/fault_o - state flags
//   fault_addr_o     - address of the request that timed out
module cu_mc
    import cu_mc_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int INSTR_W     = 32,
    parameter int DATA_W      = 64,
    parameter int INSTR_BYTES = 4,
    parameter int RESET_IP    = 0,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               resume_i,
    cu_mc_if.master            bus,
    output logic [INSTR_W-1:0] ir_o,
    input  op_class_t          dec_op_i,
    input  logic [ADDR_W-1:0]  dec_jmp_off_i,
    input  logic [ADDR_W-1:0]  dec_ld_addr_i,
    input  logic [1:0]         dec_ld_size_i,
    output logic               alu_en_o,
    output logic               rf_we_o,
    output logic               rf_wsel_o,
    output logic [DATA_W-1:0]  ld_data_o,
    output logic               halted_o,
    output logic               fault_o,
    output logic [ADDR_W-1:0]  fault_addr_o
);

    localparam int TMR_W = cu_timeout_w(MEM_TIMEOUT);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  ip_q, ip_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0]  ld_data_q, ld_data_d;
    logic [ADDR_W-1:0]  fault_addr_q, fault_addr_d;

    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic [1:0]         mem_size;
    logic               putc;
    logic               alu_en;
    logic               rf_we;
    logic               rf_wsel;

    logic               tmr_clr;
    logic               tmr_cnt;
    logic               tmr_expired;

    // Offset is in instructions; the modular product gives the byte delta
    // for negative offsets as well.
    logic [ADDR_W-1:0]  jmp_delta;
    assign jmp_delta = dec_jmp_off_i * ADDR_W'(INSTR_BYTES);

    always_comb begin
        state_d      = state_q;
        ip_d         = ip_q;
        ir_d         = ir_q;
        ld_data_d    = ld_data_q;
        fault_addr_d = fault_addr_q;
        mem_req      = 1'b0;
        mem_addr     = ip_q;
        mem_size     = SZ_LONG;
        putc         = 1'b0;
        alu_en       = 1'b0;
        rf_we        = 1'b0;
        rf_wsel      = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                // Ready in the expiry cycle still completes the fetch.
                if (bus.mem_ready) begin
                    ir_d    = bus.mem_rdata[INSTR_W-1:0];
                    state_d = ST_DECODE;
                end else if (tmr_expired) begin
                    fault_addr_d = mem_addr;
                    state_d      = ST_FAULT;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                case (dec_op_i)
                    OP_ALU: begin
                        alu_en  = 1'b1;
                        state_d = ST_INCREMENT;
                    end
                    OP_LOAD: state_d = ST_MEM_WAIT;
                    OP_PUTC: state_d = ST_IO_WAIT;
                    OP_HALT: state_d = ST_HALTED;
                    default: state_d = ST_INCREMENT;
                endcase
            end
            ST_MEM_WAIT: begin
                mem_req  = 1'b1;
                mem_addr = dec_ld_addr_i;
                mem_size = dec_ld_size_i;
                if (bus.mem_ready) begin
                    ld_data_d = bus.mem_rdata;
                    state_d   = ST_INCREMENT;
                end else if (tmr_expired) begin
                    fault_addr_d = mem_addr;
                    state_d      = ST_FAULT;
                end
            end
            ST_IO_WAIT: begin
                putc = 1'b1;
                if (bus.putc_ready) begin
                    state_d = ST_INCREMENT;
                end
            end
            ST_INCREMENT: begin
                rf_we   = (dec_op_i == OP_ALU) || (dec_op_i == OP_LOAD);
                rf_wsel = (dec_op_i == OP_LOAD);
                if (dec_op_i == OP_JMP) begin
                    ip_d = ip_q + jmp_delta;
                end else begin
                    ip_d = ip_q + ADDR_W'(INSTR_BYTES);
                end
                state_d = ST_FETCH;
            end
            ST_HALTED: begin
                if (resume_i) begin
                    state_d = ST_INCREMENT;
                end
            end
            ST_FAULT: begin
                if (resume_i) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase

        // Disabled (or in reset): hold every register and drop all strobes,
        // which also makes the unit deaf to ready/putc_ready.
        if (!en_i || rst) begin
            state_d      = state_q;
            ip_d         = ip_q;
            ir_d         = ir_q;
            ld_data_d    = ld_data_q;
            fault_addr_d = fault_addr_q;
            mem_req      = 1'b0;
            putc         = 1'b0;
            alu_en       = 1'b0;
            rf_we        = 1'b0;
            rf_wsel      = 1'b0;
        end
    end

    // Counter restarts whenever a new state is entered; it only advances on
    // live request cycles that saw no ready.
    assign tmr_clr = en_i && (state_d != state_q);
    assign tmr_cnt = mem_req && !bus.mem_ready;

    cu_wait_timer #(
        .LIMIT (MEM_TIMEOUT),
        .CNT_W (TMR_W)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (tmr_clr),
        .cnt_en_i  (tmr_cnt),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            ip_q         <= ADDR_W'(RESET_IP);
            ir_q         <= '0;
            ld_data_q    <= '0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            ip_q         <= ip_d;
            ir_q         <= ir_d;
            ld_data_q    <= ld_data_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign bus.mem_req   = mem_req;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_size  = mem_size;
    assign bus.putc      = putc;

    assign ir_o         = ir_q;
    assign alu_en_o     = alu_en;
    assign rf_we_o      = rf_we;
    assign rf_wsel_o    = rf_wsel;
    assign ld_data_o    = ld_data_q;
    assign halted_o     = (state_q == ST_HALTED);
    assign fault_o      = (state_q == ST_FAULT);
    assign fault_addr_o = fault_addr_q;

endmodule
